ef_gpio_core: RTL



---
 rtl/ef_gpio_pkg.sv | 26 ++
 rtl/ef_gpio_pin_filter.sv | 65 ++++++
 rtl/ef_gpio_core.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ef_gpio_pkg.sv
// Shared constants for the ef_gpio core: register word offsets and interrupt-mode encodings.
// Optional build macro used elsewhere in this slice: GPIO_DEBOUNCE_EN.
package ef_gpio_pkg;

    localparam int ADDR_W = 4;

    localparam logic [ADDR_W-1:0] GPIO_DATAI = 4'd0;
    localparam logic [ADDR_W-1:0] GPIO_DATAO = 4'd1;
    localparam logic [ADDR_W-1:0] GPIO_DIR   = 4'd2;
    localparam logic [ADDR_W-1:0] GPIO_SET   = 4'd3;
    localparam logic [ADDR_W-1:0] GPIO_CLR   = 4'd4;
    localparam logic [ADDR_W-1:0] GPIO_TGL   = 4'd5;
    localparam logic [ADDR_W-1:0] GPIO_IM    = 4'd6;
    localparam logic [ADDR_W-1:0] GPIO_RIS   = 4'd7;
    localparam logic [ADDR_W-1:0] GPIO_MIS   = 4'd8;
    localparam logic [ADDR_W-1:0] GPIO_ICR   = 4'd9;
    localparam logic [ADDR_W-1:0] GPIO_ITYPE = 4'd10;
    localparam logic [ADDR_W-1:0] GPIO_IPOL  = 4'd11;
    localparam logic [ADDR_W-1:0] GPIO_IBOTH = 4'd12;

    localparam logic ITYPE_LEVEL = 1'b0;
    localparam logic ITYPE_EDGE  = 1'b1;
    localparam logic IPOL_LOW    = 1'b0;
    localparam logic IPOL_HIGH   = 1'b1;

endpackage

// File: rtl/ef_gpio_pin_filter.sv
// Per-pin input conditioning: synchroniser, optional debounce (GPIO_DEBOUNCE_EN),
// delayed copy and rise/fall detection on the conditioned value.
module ef_gpio_pin_filter
    import ef_gpio_pkg::*;
#(
    parameter int SYNC_STAGES = 2
`ifdef GPIO_DEBOUNCE_EN
    ,
    parameter int DB_CYCLES = 4
`endif
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pad,
    output logic o_val,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_s;
    logic                   w_filt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pad};
            r_prev <= w_filt;
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
    logic       r_filt;
    logic [7:0] r_cnt;

    // The filtered value only follows s after DB_CYCLES consecutive disagreeing cycles.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_filt <= 1'b0;
            r_cnt  <= '0;
        end else if (w_s == r_filt) begin
            r_cnt  <= '0;
        end else if (r_cnt == 8'(DB_CYCLES - 1)) begin
            r_filt <= w_s;
            r_cnt  <= '0;
        end else begin
            r_cnt  <= r_cnt + 8'd1;
        end
    end

    assign w_filt = r_filt;
`else
    assign w_filt = w_s;
`endif

    assign o_val  = w_filt;
    assign o_rise = w_filt & ~r_prev;
    assign o_fall = ~w_filt & r_prev;

endmodule

// File: rtl/ef_gpio_core.sv
// Bus-agnostic GPIO core: data/direction registers, atomic set/clear/toggle, per-pin
// interrupt detection with sticky status and W1C clear. Optional macro: GPIO_DEBOUNCE_EN.
module ef_gpio_core
    import ef_gpio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [WIDTH-1:0]  io_in,
    output logic [WIDTH-1:0]  io_out,
    output logic [WIDTH-1:0]  io_oe,
    input  logic              reg_we,
    input  logic              reg_re,
    input  logic [ADDR_W-1:0] reg_addr,
    input  logic [31:0]       reg_wdata,
    output logic [31:0]       reg_rdata,
    output logic              IRQ
);

`ifdef GPIO_DEBOUNCE_EN
    localparam bit DB_ON = 1'b1;
`else
    localparam bit DB_ON = 1'b0;
`endif
    // Detection stays blocked until the conditioned inputs have settled after reset.
    localparam int PRIME_CNT = SYNC_STAGES + 1 + (DB_ON ? DB_CYCLES + 1 : 0);
    localparam int PRIME_W   = $clog2(PRIME_CNT + 1);

    logic [WIDTH-1:0]   r_datao, r_dir, r_im, r_ris, r_itype, r_ipol, r_iboth;
    logic [31:0]        r_rdata;
    logic               r_irq;
    logic [PRIME_W-1:0] r_prime;

    logic [WIDTH-1:0]   w_datai, w_rise, w_fall, w_set, w_clr, w_wd;
    logic [31:0]        w_rmux;
    logic               w_primed;
    logic               w_unused;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        ef_gpio_pin_filter #(
            .SYNC_STAGES(SYNC_STAGES)
`ifdef GPIO_DEBOUNCE_EN
            ,
            .DB_CYCLES(DB_CYCLES)
`endif
        ) u_filt (
            .i_clk (CLK),
            .i_rst (RESET),
            .i_pad (io_in[i]),
            .o_val (w_datai[i]),
            .o_rise(w_rise[i]),
            .o_fall(w_fall[i])
        );
    end

    assign w_wd     = reg_wdata[WIDTH-1:0];
    assign w_unused = ^reg_wdata;
    assign w_primed = (r_prime == PRIME_W'(PRIME_CNT));
    assign w_clr    = (reg_we && reg_addr == GPIO_ICR) ? w_wd : '0;

    // Level conditions are gated by the prime counter too: the synchroniser output is
    // meaningless until it has filled, and would otherwise fake a low level at reset.
    always_comb begin
        w_set = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (r_itype[i] == ITYPE_EDGE) begin
                if (r_iboth[i])
                    w_set[i] = w_rise[i] | w_fall[i];
                else
                    w_set[i] = (r_ipol[i] == IPOL_HIGH) ? w_rise[i] : w_fall[i];
            end else begin
                w_set[i] = (r_ipol[i] == IPOL_HIGH) ? w_datai[i] : ~w_datai[i];
            end
        end
        if (!w_primed)
            w_set = '0;
    end

    always_comb begin
        w_rmux = '0;
        case (reg_addr)
            GPIO_DATAI: w_rmux = 32'(w_datai);
            GPIO_DATAO: w_rmux = 32'(r_datao);
            GPIO_DIR:   w_rmux = 32'(r_dir);
            GPIO_IM:    w_rmux = 32'(r_im);
            GPIO_RIS:   w_rmux = 32'(r_ris);
            GPIO_MIS:   w_rmux = 32'(r_ris & r_im);
            GPIO_ITYPE: w_rmux = 32'(r_itype);
            GPIO_IPOL:  w_rmux = 32'(r_ipol);
            GPIO_IBOTH: w_rmux = 32'(r_iboth);
            default:    w_rmux = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_datao <= '0;
            r_dir   <= '0;
            r_im    <= '0;
            r_ris   <= '0;
            r_itype <= '0;
            r_ipol  <= '0;
            r_iboth <= '0;
            r_rdata <= '0;
            r_irq   <= 1'b0;
            r_prime <= '0;
        end else begin
            if (reg_we) begin
                case (reg_addr)
                    GPIO_DATAO: r_datao <= w_wd;
                    GPIO_DIR:   r_dir   <= w_wd;
                    GPIO_SET:   r_datao <= r_datao | w_wd;
                    GPIO_CLR:   r_datao <= r_datao & ~w_wd;
                    GPIO_TGL:   r_datao <= r_datao ^ w_wd;
                    GPIO_IM:    r_im    <= w_wd;
                    GPIO_ITYPE: r_itype <= w_wd;
                    GPIO_IPOL:  r_ipol  <= w_wd;
                    GPIO_IBOTH: r_iboth <= w_wd;
                    default: ;
                endcase
            end
            // Set beats clear so a persisting level interrupt cannot be cleared away.
            r_ris <= (r_ris & ~w_clr) | w_set;
            r_irq <= |(r_ris & r_im);
            if (reg_re)
                r_rdata <= w_rmux;
            if (!w_primed)
                r_prime <= r_prime + PRIME_W'(1);
        end
    end

    assign io_out    = r_datao;
    assign io_oe     = r_dir;
    assign reg_rdata = r_rdata;
    assign IRQ       = r_irq;

endmodule
